mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit_pkg.sv | 28 ++
 rtl/mult_div_unit_latency_counter.sv | 47 ++++
 rtl/mult_div_unit.sv | 157 +++++++++++++++
 tb/tb_mult_div_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit.
// Imported by the unit itself, the decoder/CU and the D-stage stall logic so
// that all of them agree on the op encoding and the default latencies.
// No ports (package).
package mult_div_unit_pkg;

  localparam logic [3:0] MDU_MULT  = 4'd0;
  localparam logic [3:0] MDU_MULTU = 4'd1;
  localparam logic [3:0] MDU_DIV   = 4'd2;
  localparam logic [3:0] MDU_DIVU  = 4'd3;
  localparam logic [3:0] MDU_MFHI  = 4'd4;
  localparam logic [3:0] MDU_MFLO  = 4'd5;
  localparam logic [3:0] MDU_MTHI  = 4'd6;
  localparam logic [3:0] MDU_MTLO  = 4'd7;
  localparam logic [3:0] MDU_MADD  = 4'd8;
  localparam logic [3:0] MDU_MADDU = 4'd9;
  localparam logic [3:0] MDU_MSUB  = 4'd10;
  localparam logic [3:0] MDU_MSUBU = 4'd11;

  localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
  localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;
  localparam int unsigned MDU_CNT_W_DEF       = 4;

  function automatic logic mdu_is_div(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_latency_counter.sv
// mdu_latency_counter: occupancy FSM of the multiply-divide unit.
// IDLE while the count is zero, RUN while non-zero. A load in IDLE sets the
// count; RUN decrements once per edge back to zero.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   load        request to start a timed operation (honoured only in IDLE)
//   load_val    number of busy cycles for that operation
//   busy        count is non-zero (straight from the register)
//   done        high during the last busy cycle, i.e. the edge ending it
//               takes the count 1->0
module mdu_latency_counter
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned CNT_W = MDU_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [CNT_W-1:0] count;
  logic [0:0]       state;

  assign state = (count == '0) ? ST_IDLE : ST_RUN;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      case (state)
        ST_IDLE: if (load) count <= load_val;
        ST_RUN:  count <= count - CNT_W'(1);
        default: count <= '0;
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_RUN) && (count == CNT_W'(1));

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: E-stage HI/LO multiply-divide unit.
// MULT/MULTU/DIV/DIVU run for a fixed number of cycles; MTHI/MTLO write in
// one cycle; MFHI/MFLO read combinationally through rd_data.
// Optional feature macro: MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU (ops 8-11).
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   start       E-stage instruction is a timed mult/div op
//   op          operation code (mult_div_unit_pkg constants)
//   a, b        forwarded rs / rt values
//   we          E-stage instruction is valid; qualifies start and MTHI/MTLO
//   busy        a timed operation is in progress (registered)
//   hi, lo      architectural HI / LO
//   rd_data     MFHI -> hi, MFLO -> lo, otherwise 0
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = MDU_CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        we,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  logic             timed_op;
  logic             accept;
  logic             done;
  logic [CNT_W-1:0] load_val;
  logic [3:0]       op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;

  always_comb begin
    timed_op = 1'b0;
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: timed_op = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: timed_op = 1'b1;
`endif
      default: timed_op = 1'b0;
    endcase
  end

  assign accept   = start && we && !busy && timed_op;
  assign load_val = mdu_is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  mdu_latency_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (load_val),
    .busy     (busy),
    .done     (done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (accept) begin
      op_q <= op;
      a_q  <= a;
      b_q  <= b;
    end
  end

  // Low 64 bits of a 64x64 product of the extended operands are exactly the
  // 32x32 signed (or unsigned) product.
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed division via magnitudes: truncation toward zero and a remainder
  // carrying the dividend's sign fall out naturally, and 0x80000000 / -1
  // yields quotient 0x80000000, remainder 0 without a special case.
  logic        a_neg;
  logic        b_neg;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  assign a_neg   = (op_q == MDU_DIV) && a_q[31];
  assign b_neg   = (op_q == MDU_DIV) && b_q[31];
  assign mag_a   = a_neg ? (32'd0 - a_q) : a_q;
  assign mag_b   = b_neg ? (32'd0 - b_q) : b_q;
  assign divisor = (mag_b == '0) ? 32'd1 : mag_b;
  assign q_mag   = mag_a / divisor;
  assign r_mag   = mag_a % divisor;
  assign quot    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem     = a_neg ? (32'd0 - r_mag) : r_mag;

  logic        res_we;
  logic [63:0] res;

  always_comb begin
    res_we = 1'b0;
    res    = {hi, lo};
    case (op_q)
      MDU_MULT:  begin res_we = 1'b1; res = prod_s; end
      MDU_MULTU: begin res_we = 1'b1; res = prod_u; end
      MDU_DIV, MDU_DIVU: begin
        // Division by zero leaves HI/LO untouched.
        res_we = (b_q != '0);
        res    = {rem, quot};
      end
`ifdef MDU_MADD_EN
      MDU_MADD:  begin res_we = 1'b1; res = {hi, lo} + prod_s; end
      MDU_MADDU: begin res_we = 1'b1; res = {hi, lo} + prod_u; end
      MDU_MSUB:  begin res_we = 1'b1; res = {hi, lo} - prod_s; end
      MDU_MSUBU: begin res_we = 1'b1; res = {hi, lo} - prod_u; end
`endif
      default: begin res_we = 1'b0; res = {hi, lo}; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (done) begin
      if (res_we) begin
        hi <= res[63:32];
        lo <= res[31:0];
      end
    end else if (we && !busy) begin
      if (op == MDU_MTHI) hi <= a;
      if (op == MDU_MTLO) lo <= a;
    end
  end

  always_comb begin
    rd_data = '0;
    case (op)
      MDU_MFHI: rd_data = hi;
      MDU_MFLO: rd_data = lo;
      default:  rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed scenarios followed by
// randomized operations, checked against an arithmetic reference model.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        we;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  always #5 clk = ~clk;

  mult_div_unit #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .we      (we),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .rd_data (rd_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat_of(input logic [3:0] o);
    return (o == MDU_DIV || o == MDU_DIVU) ? 10 : 5;
  endfunction

  // Reference: the architectural effect of one completed timed operation.
  task automatic model_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int          ix, iy;
    longint      sx, sy, q, r;
    longint unsigned ux, uy;
    logic [63:0] acc;
    ix = x; iy = y; sx = ix; sy = iy;
    ux = {32'd0, x}; uy = {32'd0, y};
    acc = {exp_hi, exp_lo};
    case (o)
      MDU_MULT:  acc = sx * sy;
      MDU_MULTU: acc = ux * uy;
      MDU_DIV: if (y != 0) begin
        q = sx / sy; r = sx % sy;
        acc = {r[31:0], q[31:0]};
      end
      MDU_DIVU: if (y != 0) begin
        q = longint'(ux / uy); r = longint'(ux % uy);
        acc = {r[31:0], q[31:0]};
      end
      MDU_MADD:  acc = acc + 64'(sx * sy);
      MDU_MADDU: acc = acc + (ux * uy);
      MDU_MSUB:  acc = acc - 64'(sx * sy);
      MDU_MSUBU: acc = acc - (ux * uy);
      default: ;
    endcase
    exp_hi = acc[63:32];
    exp_lo = acc[31:0];
  endtask

  // Issue one timed op; optionally fire a conflicting start mid-operation.
  task automatic do_mdu(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit inject);
    int cycles;
    start = 1'b1; we = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0; we = 1'b0; op = MDU_MFHI;
    chk("busy_rise", {31'd0, busy}, 32'd1);
    cycles = 0;
    while (busy === 1'b1 && cycles < 40) begin
      if (cycles == 0) chk("hi_held_while_busy", hi, exp_hi);
      if (inject && cycles == 1) begin
        start = 1'b1; we = 1'b1; op = MDU_MULTU;
        a = $urandom; b = $urandom;
      end
      cycles++;
      tick();
      start = 1'b0; we = 1'b0; op = MDU_MFHI;
    end
    chk("busy_len", 32'(cycles), 32'(lat_of(o)));
    model_op(o, x, y);
    chk("hi_result", hi, exp_hi);
    chk("lo_result", lo, exp_lo);
    chk("mfhi_rd", rd_data, exp_hi);
  endtask

  task automatic do_mt(input logic [3:0] o, input logic [31:0] x);
    we = 1'b1; op = o; a = x;
    tick();
    we = 1'b0;
    if (o == MDU_MTHI) exp_hi = x; else exp_lo = x;
    chk("mt_busy", {31'd0, busy}, 32'd0);
    op = MDU_MFHI; #1;
    chk("mt_mfhi", rd_data, exp_hi);
    op = MDU_MFLO; #1;
    chk("mt_mflo", rd_data, exp_lo);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; we = 1'b0; op = '0; a = '0; b = '0;
    exp_hi = '0; exp_lo = '0;
    tick(); tick();
    reset = 1'b0;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);

    do_mdu(MDU_MULT, 32'hFFFFFFFF, 32'd2, 1'b0);
    chk("mult_hi_plan", hi, 32'hFFFFFFFF);
    chk("mult_lo_plan", lo, 32'hFFFFFFFE);
    do_mdu(MDU_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0);
    chk("multu_hi_plan", hi, 32'd1);
    chk("multu_lo_plan", lo, 32'hFFFFFFFE);

    do_mdu(MDU_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    chk("div_lo_plan", lo, 32'hFFFFFFFD);
    chk("div_hi_plan", hi, 32'hFFFFFFFF);
    do_mdu(MDU_DIVU, 32'd7, 32'd2, 1'b0);
    chk("divu_lo_plan", lo, 32'd3);
    chk("divu_hi_plan", hi, 32'd1);

    do_mt(MDU_MTHI, 32'h12345678);
    do_mdu(MDU_DIV, 32'd100, 32'd0, 1'b0);
    chk("div0_hi_plan", hi, 32'h12345678);
    chk("div0_lo_plan", lo, 32'd3);

    do_mdu(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    chk("divovf_lo", lo, 32'h80000000);
    chk("divovf_hi", hi, 32'd0);

    // Conflicting start during busy must be ignored.
    do_mdu(MDU_MULT, 32'd1000, 32'hFFFFFFFD, 1'b1);
    chk("inject_lo_plan", lo, 32'hFFFFF448);

    // Reset in the third busy cycle abandons the op.
    start = 1'b1; we = 1'b1; op = MDU_MULT; a = 32'd3; b = 32'd3;
    tick();
    start = 1'b0; we = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    repeat (12) tick();
    chk("rst_late_busy", {31'd0, busy}, 32'd0);
    chk("rst_late_hi", hi, 32'd0);
    chk("rst_late_lo", lo, 32'd0);

    // Unlisted op: no start, no state change, rd_data zero.
    do_mt(MDU_MTLO, 32'hCAFEF00D);
    start = 1'b1; we = 1'b1; op = 4'd12; a = 32'h55; b = 32'h66; #1;
    chk("unlisted_rd", rd_data, 32'd0);
    tick();
    start = 1'b0; we = 1'b0;
    chk("unlisted_busy", {31'd0, busy}, 32'd0);
    chk("unlisted_hi", hi, exp_hi);
    chk("unlisted_lo", lo, exp_lo);

`ifdef MDU_MADD_EN
    do_mt(MDU_MTLO, 32'd10);
    do_mt(MDU_MTHI, 32'd0);
    do_mdu(MDU_MADD, 32'd3, 32'd4, 1'b0);
    chk("madd_lo_plan", lo, 32'd22);
    chk("madd_hi_plan", hi, 32'd0);
    do_mdu(MDU_MSUBU, 32'd1, 32'd23, 1'b0);
    chk("msubu_hi_plan", hi, 32'hFFFFFFFF);
    chk("msubu_lo_plan", lo, 32'hFFFFFFFF);
`else
    start = 1'b1; we = 1'b1; op = MDU_MADD; a = 32'd3; b = 32'd4;
    tick();
    start = 1'b0; we = 1'b0;
    chk("nomadd_busy", {31'd0, busy}, 32'd0);
    repeat (6) tick();
    chk("nomadd_hi", hi, exp_hi);
    chk("nomadd_lo", lo, exp_lo);
`endif

    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = rb & 32'hFF;
        default: ;
      endcase
`ifdef MDU_MADD_EN
      ro = 4'($urandom_range(0, 11));
`else
      ro = 4'($urandom_range(0, 7));
`endif
      if (ro == MDU_MFHI || ro == MDU_MFLO) ro = MDU_DIV;
      if (ro == MDU_MTHI || ro == MDU_MTLO) do_mt(ro, ra);
      else do_mdu(ro, ra, rb, ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
